// File: rtl/ex_mul_seq_if.sv
// Bundle of signals between the execute stage and the shift-add multiply sequencer.
// Handshake: start is a level request sampled only in IDLE/DONE; done is a one-cycle pulse with result valid; stall holds the pipeline meanwhile.
interface ex_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, op_a, op_b, alu_sum,
        input  alu_sel, alu_a, alu_b, stall, done, result
    );

    modport slave (
        input  start, flush, op_a, op_b, alu_sum,
        output alu_sel, alu_a, alu_b, stall, done, result
    );
endinterface

// File: rtl/ex_mul_seq.sv
// Shift-add multiply sequencer stepping the shared execute adder once per cycle.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module ex_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    ex_mul_seq_if.slave mul_if,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load;
    logic             last_step;

`ifdef MUL_EARLY_EXIT_EN
    assign last_step = (cnt_q == LAST_CNT) || ((mplier_q >> 1) == '0);
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        load           = 1'b0;
        mul_if.alu_sel = 1'b0;
        mul_if.alu_a   = '0;
        mul_if.alu_b   = '0;

        case (state_q)
            S_IDLE: load = mul_if.start;
            S_RUN: begin
                mul_if.alu_sel = 1'b1;
                mul_if.alu_a   = acc_q;
                mul_if.alu_b   = mplier_q[0] ? mcand_q : '0;
                acc_d          = mul_if.alu_sum;
                mcand_d        = mcand_q << 1;
                mplier_d       = mplier_q >> 1;
                cnt_d          = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = S_DONE;
                    result_d = mul_if.alu_sum;
                end
            end
            S_DONE: begin
                load    = mul_if.start;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d  = S_RUN;
            acc_d    = '0;
            mcand_d  = mul_if.op_a;
            mplier_d = mul_if.op_b;
            cnt_d    = '0;
        end

        // Squash wins over both a new start and a finishing step.
        if (mul_if.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    assign mul_if.stall  = ((state_q == S_IDLE) && mul_if.start && !mul_if.flush)
                         || (state_q == S_RUN);
    assign mul_if.done   = (state_q == S_DONE);
    assign mul_if.result = result_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_ex_mul_seq.sv
// Directed bench for ex_mul_seq: vector table of products plus flush/reset/back-to-back sequences.
module tb_ex_mul_seq;
    localparam int WIDTH = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         n_checks;
    int         n_pass;

    ex_mul_seq_if #(.WIDTH(WIDTH)) bus ();

    assign bus.alu_sum = bus.alu_a + bus.alu_b;

    ex_mul_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (bus),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, sampling 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp);
        int stalls;
        int edges;
        bit seen;
        stalls = 0;
        edges  = 0;
        seen   = 1'b0;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        #1;
        while (!seen && edges < 40) begin
            if (bus.stall) stalls++;
            if (edges == 1) begin
                check($sformatf("v%0d_alu_sel", idx), 32'(bus.alu_sel), 32'd1);
                check($sformatf("v%0d_alu_a", idx), 32'(bus.alu_a), 32'd0);
                check($sformatf("v%0d_alu_b", idx), 32'(bus.alu_b), 32'(b[0] ? a : '0));
            end
            if (bus.done) seen = 1'b1;
            else begin
                step();
                bus.start = 1'b0;
                edges++;
                #1;
            end
        end
        check($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
        check($sformatf("v%0d_latency", idx), 32'(edges), 32'd17);
        check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'd17);
        check($sformatf("v%0d_result", idx), 32'(bus.result), 32'(exp));
        check($sformatf("v%0d_done_stall", idx), 32'(bus.stall), 32'd0);
        step();
        #1;
        check($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_back_idle", idx), 32'(state_o), 32'(ST_IDLE));
        check($sformatf("v%0d_result_held", idx), 32'(bus.result), 32'(exp));
    endtask

    vec_t vecs[10];

    initial begin
        int edges;
        bit seen;
        logic [WIDTH-1:0] old_res;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;

        vecs[0] = '{16'h0003, 16'h0005, 16'h000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[2] = '{16'h8000, 16'h0002, 16'h0000};
        vecs[3] = '{16'h1234, 16'h0010, 16'h2340};
        vecs[4] = '{16'h0000, 16'h0055, 16'h0000};
        vecs[5] = '{16'h0007, 16'h0001, 16'h0007};
        vecs[6] = '{16'h00FF, 16'h0101, 16'hFFFF};
        vecs[7] = '{16'h1234, 16'h5678, 16'h0060};
        vecs[8] = '{16'hFFFD, 16'h0005, 16'hFFF1};
        vecs[9] = '{16'h0009, 16'h0000, 16'h0000};

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        step();

        foreach (vecs[i]) run_vec(i, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Flush has priority over start in IDLE
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op_a  = 16'h0003;
        bus.op_b  = 16'h0003;
        #1;
        check("flush_pri_stall", 32'(bus.stall), 32'd0);
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("flush_pri_state", 32'(state_o), 32'(ST_IDLE));

        // Flush on the fifth RUN cycle
        old_res   = bus.result;
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h0010;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        #1;
        check("flush_pre_state", 32'(state_o), 32'(ST_RUN));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        check("flush_state", 32'(state_o), 32'(ST_IDLE));
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_stall", 32'(bus.stall), 32'd0);
        check("flush_alu_sel", 32'(bus.alu_sel), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) seen = 1'b1;
            step();
            #1;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result_kept", 32'(bus.result), 32'(old_res));

        // Synchronous reset on the fifth RUN cycle
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h0010;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("rstrun_state", 32'(state_o), 32'(ST_IDLE));
        check("rstrun_result", 32'(bus.result), 32'd0);
        check("rstrun_done", 32'(bus.done), 32'd0);
        check("rstrun_stall", 32'(bus.stall), 32'd0);
        check("rstrun_alu_sel", 32'(bus.alu_sel), 32'd0);
        step();

        // Back-to-back: start held through RUN (ignored), new operands applied in DONE
        bus.start = 1'b1;
        bus.op_a  = 16'h0003;
        bus.op_b  = 16'h0005;
        step();
        bus.op_a  = 16'h7777;
        bus.op_b  = 16'h3333;
        edges = 1;
        #1;
        while (!bus.done && edges < 40) begin
            step();
            edges++;
            #1;
        end
        check("b2b_first_lat", 32'(edges), 32'd17);
        check("b2b_first_result", 32'(bus.result), 32'h000F);
        bus.op_a = 16'h0006;
        bus.op_b = 16'h0007;
        step();
        bus.start = 1'b0;
        #1;
        check("b2b_no_idle", 32'(state_o), 32'(ST_RUN));
        edges = 1;
        while (!bus.done && edges < 40) begin
            step();
            edges++;
            #1;
        end
        check("b2b_second_gap", 32'(edges), 32'd17);
        check("b2b_second_done", 32'(bus.done), 32'd1);
        check("b2b_second_result", 32'(bus.result), 32'h002A);
        step();
        #1;
        check("b2b_end_state", 32'(state_o), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
